// File: rtl/load_seq_if.sv
// Load sequencer bus bundle: execute-stage load request, data-memory read port
// and writeback return, with the sequencer on the master side.
interface load_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_addr;
    logic [2:0]            ld_funct3;
    logic [4:0]            ld_rd;

    logic                  mem_req;
    logic                  mem_gnt;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [4:0]            wb_rd;
    logic                  wb_fault;

    modport master (
        input  ld_valid, ld_addr, ld_funct3, ld_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  wb_ready,
        output ld_ready,
        output mem_req, mem_addr,
        output wb_valid, wb_data, wb_rd, wb_fault
    );

    modport slave (
        output ld_valid, ld_addr, ld_funct3, ld_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        output wb_ready,
        input  ld_ready,
        input  mem_req, mem_addr,
        input  wb_valid, wb_data, wb_rd, wb_fault
    );
endinterface

// File: rtl/load_seq.sv
// Load sequencer for core_l1: one load at a time, one or two word reads, byte/half/word
// extraction and extension. Define LOAD_SEQ_MISALIGNED_EN to allow misaligned LH/LHU/LW.

module signext (
    input  logic [2:0]  op,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    localparam logic [2:0] SX_0700  = 3'd0;
    localparam logic [2:0] SX_1500  = 3'd1;
    localparam logic [2:0] SX_3100  = 3'd2;
    localparam logic [2:0] SXU_0700 = 3'd4;
    localparam logic [2:0] SXU_1500 = 3'd5;

    always_comb begin
        dout = din;
        case (op)
            SX_0700:  dout = {{24{din[7]}}, din[7:0]};
            SX_1500:  dout = {{16{din[15]}}, din[15:0]};
            SX_3100:  dout = din;
            SXU_0700: dout = {24'h000000, din[7:0]};
            SXU_1500: dout = {16'h0000, din[15:0]};
            default:  dout = din;
        endcase
    end
endmodule

module load_seq #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    load_seq_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] SX_0700  = 3'd0;
    localparam logic [2:0] SX_1500  = 3'd1;
    localparam logic [2:0] SX_3100  = 3'd2;
    localparam logic [2:0] SXU_0700 = 3'd4;
    localparam logic [2:0] SXU_1500 = 3'd5;

`ifdef LOAD_SEQ_MISALIGNED_EN
    localparam bit MISALIGNED_EN = 1'b1;
`else
    localparam bit MISALIGNED_EN = 1'b0;
`endif

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [4:0]            wb_rd_q;
    logic                  wb_fault_q;

    logic [2:0]              req_size;
    logic                    req_misaligned;
    logic                    req_fault;
    logic                    crosses;
    logic [DATA_WIDTH-1:0]   ext_lo;
    logic [DATA_WIDTH-1:0]   ext_hi;
    logic [2*DATA_WIDTH-1:0] pair;
    logic [DATA_WIDTH-1:0]   raw;
    logic [2:0]              sx_op;
    logic [DATA_WIDTH-1:0]   sx_out;

    // Access size in bytes; 0 marks an unsupported funct3.
    function automatic logic [2:0] load_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: load_size = 3'd1;
            3'd1, 3'd5: load_size = 3'd2;
            3'd2:       load_size = 3'd4;
            default:    load_size = 3'd0;
        endcase
    endfunction

    always_comb begin
        req_size       = load_size(bus.ld_funct3);
        req_misaligned = ((req_size == 3'd2) && bus.ld_addr[0]) ||
                         ((req_size == 3'd4) && (bus.ld_addr[1:0] != 2'b00));
        req_fault      = (req_size == 3'd0) || (req_misaligned && !MISALIGNED_EN);
    end

`ifdef LOAD_SEQ_MISALIGNED_EN
    assign crosses = ({1'b0, addr_q[1:0]} + load_size(funct3_q)) > 3'd4;
`else
    assign crosses = 1'b0;
`endif

    // The word arriving this cycle bypasses its buffer so wb_data can be
    // registered on the same edge that enters RESP.
    always_comb begin
        ext_lo = buf0;
        ext_hi = buf1;
        if (state == S_WAIT0) begin
            ext_lo = bus.mem_rdata;
        end
        if (state == S_WAIT1) begin
            ext_hi = bus.mem_rdata;
        end
        pair = {ext_hi, ext_lo} >> {addr_q[1:0], 3'b000};
        raw  = pair[DATA_WIDTH-1:0];
    end

    always_comb begin
        sx_op = SX_3100;
        case (funct3_q)
            3'd0:    sx_op = SX_0700;
            3'd1:    sx_op = SX_1500;
            3'd2:    sx_op = SX_3100;
            3'd4:    sx_op = SXU_0700;
            3'd5:    sx_op = SXU_1500;
            default: sx_op = SX_3100;
        endcase
    end

    signext u_signext (
        .op   (sx_op),
        .din  (raw),
        .dout (sx_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            funct3_q   <= 3'd0;
            rd_q       <= 5'd0;
            buf0       <= '0;
            buf1       <= '0;
            mem_addr_q <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            wb_fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ld_valid) begin
                        addr_q   <= bus.ld_addr;
                        funct3_q <= bus.ld_funct3;
                        rd_q     <= bus.ld_rd;
                        if (req_fault) begin
                            wb_data_q  <= '0;
                            wb_rd_q    <= bus.ld_rd;
                            wb_fault_q <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            mem_addr_q <= {bus.ld_addr[DATA_WIDTH-1:2], 2'b00};
                            state      <= S_REQ0;
                        end
                    end
                end
                S_REQ0: begin
                    if (bus.mem_gnt) begin
                        state <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (bus.mem_rvalid) begin
                        buf0 <= bus.mem_rdata;
                        if (crosses) begin
                            mem_addr_q <= mem_addr_q + DATA_WIDTH'(4);
                            state      <= S_REQ1;
                        end else begin
                            wb_data_q  <= sx_out;
                            wb_rd_q    <= rd_q;
                            wb_fault_q <= 1'b0;
                            state      <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (bus.mem_gnt) begin
                        state <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (bus.mem_rvalid) begin
                        buf1       <= bus.mem_rdata;
                        wb_data_q  <= sx_out;
                        wb_rd_q    <= rd_q;
                        wb_fault_q <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.wb_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ld_ready = (state == S_IDLE);
    assign bus.mem_req  = (state == S_REQ0) || (state == S_REQ1);
    assign bus.mem_addr = mem_addr_q;
    assign bus.wb_valid = (state == S_RESP);
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_fault = wb_fault_q;
endmodule

// File: tb/tb_load_seq.sv
// Scoreboard bench for load_seq: byte-level memory model predicts each writeback,
// a cycle loop plays the memory and writeback sides with configurable stalls.
module tb_load_seq;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    load_seq_if #(.DATA_WIDTH(32)) bus ();

    load_seq #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef LOAD_SEQ_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic        fault;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem_model [logic [31:0]];
    exp_t        sb [$];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem_model.exists(w)) return mem_model[w];
        return ~w;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        case (a[1:0])
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Expected {fault, data}, assembled byte by byte little-endian.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [2:0] f3);
        int          sz;
        logic        mis;
        logic [31:0] v;
        sz = size_of(f3);
        if (sz == 0) return {1'b1, 32'h0};
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        if (mis && !MIS_EN) return {1'b1, 32'h0};
        v = 32'h0;
        for (int i = 0; i < sz; i++) begin
            v = v | (32'(mem_byte(a + 32'(i))) << (8 * i));
        end
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return {1'b0, v};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                                 input int gd, input int rdly);
        logic [32:0] m;
        exp_t        e;
        exp_t        got;
        int          nreads, cyc, reqs, waitc, held;
        logic        pend, seen_wb, ready_sent, done;
        logic [31:0] gaddr, eaddr;

        m       = model(a, f3);
        nreads  = m[32] ? 0 : ((int'(a[1:0]) + size_of(f3) > 4) ? 2 : 1);
        e.fault = m[32];
        e.data  = m[31:0];
        e.rd    = rd;
        got     = '0;

        @(negedge clk);
        checkOutput("ld_ready_idle", 32'(bus.ld_ready), 32'd1);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = a;
        bus.ld_funct3 = f3;
        bus.ld_rd     = rd;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        sb.push_back(e);

        cyc = 1; reqs = 0; waitc = 0; held = 0;
        pend = 1'b0; seen_wb = 1'b0; ready_sent = 1'b0; done = 1'b0;
        gaddr = 32'h0;
        while (!done && cyc < 200) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.wb_ready   = 1'b0;
            if (pend) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word(gaddr);
                pend = 1'b0;
            end
            if (bus.mem_req) begin
                eaddr = {a[31:2], 2'b00} + ((reqs == 0) ? 32'd0 : 32'd4);
                checkOutput("mem_addr", bus.mem_addr, eaddr);
                if (waitc < gd) begin
                    waitc++;
                end else begin
                    bus.mem_gnt = 1'b1;
                    gaddr = bus.mem_addr;
                    reqs++;
                    waitc = 0;
                    pend  = 1'b1;
                end
            end
            if (ready_sent) begin
                checkOutput("wb_once", 32'(bus.wb_valid), 32'd0);
                checkOutput("ld_ready_after", 32'(bus.ld_ready), 32'd1);
                done = 1'b1;
            end else if (bus.wb_valid) begin
                if (!seen_wb) begin
                    seen_wb = 1'b1;
                    got = sb.pop_front();
                    checkOutput("wb_latency", 32'(cyc), 32'(1 + nreads * (gd + 2)));
                end
                checkOutput("wb_data", bus.wb_data, got.data);
                checkOutput("wb_rd", 32'(bus.wb_rd), 32'(got.rd));
                checkOutput("wb_fault", 32'(bus.wb_fault), 32'(got.fault));
                if (held < rdly) begin
                    held++;
                end else begin
                    bus.wb_ready = 1'b1;
                    ready_sent = 1'b1;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) checkOutput("timeout", 32'd1, 32'd0);
        checkOutput("mem_reads", 32'(reqs), 32'(nreads));
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.wb_ready   = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = 32'h0;
        bus.ld_funct3  = 3'd0;
        bus.ld_rd      = 5'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.wb_ready   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        checkOutput("rst_wb_data", bus.wb_data, 32'h0);
        checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        checkOutput("rst_wb_fault", 32'(bus.wb_fault), 32'd0);
        rst_n = 1'b1;

        mem_model[32'h1000] = 32'h80000000;
        applyStimulus(32'h1003, 3'd0, 5'd7, 0, 0);
        mem_model[32'h2000] = 32'hBEEF1234;
        applyStimulus(32'h2002, 3'd5, 5'd3, 0, 0);
        applyStimulus(32'h2002, 3'd1, 5'd4, 0, 0);
        mem_model[32'h1000] = 32'h44332211;
        mem_model[32'h1004] = 32'h88776655;
        applyStimulus(32'h1000, 3'd2, 5'd9, 4, 3);
        applyStimulus(32'h1001, 3'd2, 5'd10, 0, 0);
        applyStimulus(32'h1003, 3'd1, 5'd11, 1, 0);
        applyStimulus(32'h1006, 3'd5, 5'd12, 0, 1);
        applyStimulus(32'h1001, 3'd5, 5'd13, 0, 0);
        applyStimulus(32'h1007, 3'd4, 5'd14, 2, 0);
        applyStimulus(32'h1000, 3'd3, 5'd15, 0, 0);
        applyStimulus(32'h1000, 3'd6, 5'd16, 0, 2);
        applyStimulus(32'h1000, 3'd7, 5'd17, 0, 0);

        for (int i = 0; i < 10; i++) begin
            mem_model[32'h4000 + 32'(4 * i)] = $urandom;
        end
        for (int i = 0; i < 24; i++) begin
            applyStimulus(32'h4000 + 32'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while waiting for read data; the late response must be dropped.
        @(negedge clk);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h1000;
        bus.ld_funct3 = 3'd2;
        bus.ld_rd     = 5'd21;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        checkOutput("abort_mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checkOutput("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        checkOutput("abort_ld_ready", 32'(bus.ld_ready), 32'd1);
        checkOutput("abort_mem_req2", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        checkOutput("abort_wb_valid2", 32'(bus.wb_valid), 32'd0);
        checkOutput("abort_wb_data", bus.wb_data, 32'h0);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
